// File: rtl/rsc_frame_encoder.sv
// Rate-1/2 RSC encoder (g0=1+D^2+D^3 feedback, g1=1+D+D^3 parity) with frame counting and 3-step trellis termination.
// Latency: 1 cycle from an input handshake (or tail step) to out_valid.
// Backpressure: one output register; while out_valid && !out_ready the outputs hold and no step fires (in_ready=0).
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start                 begin a frame (honoured only when idle)
//   in_valid/in_bit       info bit offer; in_ready = encoder takes it this cycle
//   out_valid/out_ready   symbol pair handshake
//   out_sys/out_par       systematic / parity bit (tail: termination bit / parity)
//   out_tail/out_last     symbol is a tail symbol / is the final tail symbol
//   busy                  frame in progress (cycle after start .. last tail handshake)
//   frame_done            one-cycle pulse on the last tail handshake
module rsc_frame_encoder #(
  parameter int BLOCK_LEN = 6144,
  parameter int MEM       = 3,
  localparam int CW       = $clog2(BLOCK_LEN + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic in_valid,
  input  logic in_bit,
  output logic in_ready,
  output logic out_valid,
  input  logic out_ready,
  output logic out_sys,
  output logic out_par,
  output logic out_tail,
  output logic out_last,
  output logic busy,
  output logic frame_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_TAIL  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   count_q;
  logic [1:0]      tcnt_q;
  logic [1:MEM]    s_q;
  logic [1:MEM]    s_d;

  logic            out_valid_q;
  logic            out_sys_q;
  logic            out_par_q;
  logic            out_tail_q;
  logic            out_last_q;
  logic            busy_q;

  logic            step_ok;
  logic            data_fire;
  logic            tail_fire;
  logic            fire;
  logic            u;
  logic            a;
  logic            p;

  always_comb begin
    step_ok   = !out_valid_q || out_ready;
    data_fire = (state_q == S_DATA) && in_valid && step_ok;
    tail_fire = (state_q == S_TAIL) && step_ok;
    fire      = data_fire || tail_fire;
    // Tail input cancels the feedback term, so the register shifts in zeros.
    u         = (state_q == S_TAIL) ? (s_q[2] ^ s_q[3]) : in_bit;
    a         = u ^ s_q[2] ^ s_q[3];
    p         = a ^ s_q[1] ^ s_q[3];
    s_d       = {a, s_q[1:MEM-1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      tcnt_q      <= '0;
      s_q         <= '0;
      out_valid_q <= 1'b0;
      out_sys_q   <= 1'b0;
      out_par_q   <= 1'b0;
      out_tail_q  <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_DATA;
            count_q <= '0;
            s_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_DATA: begin
          if (data_fire) begin
            count_q <= count_q + CW'(1);
            if (count_q == CW'(BLOCK_LEN - 1)) begin
              state_q <= S_TAIL;
              tcnt_q  <= '0;
            end
          end
        end
        S_TAIL: begin
          if (tail_fire) begin
            tcnt_q <= tcnt_q + 2'd1;
            if (tcnt_q == 2'd2) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Last tail symbol leaves the output register; encoder is already back at 000.
          if (out_valid_q && out_ready) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (fire) begin
        s_q         <= s_d;
        out_valid_q <= 1'b1;
        out_sys_q   <= u;
        out_par_q   <= p;
        out_tail_q  <= tail_fire;
        out_last_q  <= tail_fire && (tcnt_q == 2'd2);
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
        out_tail_q  <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign in_ready   = (state_q == S_DATA) && step_ok;
  assign out_valid  = out_valid_q;
  assign out_sys    = out_sys_q;
  assign out_par    = out_par_q;
  assign out_tail   = out_tail_q;
  assign out_last   = out_last_q;
  assign busy       = busy_q;
  // A reset in the drain cycle discards the frame, so no completion is reported.
  assign frame_done = !reset && (state_q == S_DRAIN) && out_valid_q && out_ready;

endmodule
